// File: rtl/adat_rx_adat_tx.sv
// ---------------------------------------------------------------------------
// adat_rx_adat_tx
//   ADAT optical-line transmitter. Takes one 8 x 24-bit sample frame plus four
//   user bits per word clock and serialises it as a 256-bit NRZI ADAT frame.
//   Bit timing comes from a fractional phase accumulator running on i_clk.
//
// Ports
//   i_clk          system clock, all logic on its rising edge
//   i_rst          synchronous active-high reset
//   i_channels     channel samples [0:7], sent MSB first
//   i_user         user bits, sent U3..U0
//   i_valid        one-cycle strobe, writes the holding buffer
//   o_ready        high while the holding buffer is empty
//   o_adat         NRZI line output
//   o_frame_start  pulse on the tick that emits frame bit 0
//   o_underrun     pulse when a frame is loaded with the holding buffer empty
//   o_overrun      pulse when i_valid overwrites a full holding buffer
//   o_active       high in any state except IDLE
// ---------------------------------------------------------------------------
module adat_rx_adat_tx #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int SAMPLE_RATE = 48000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [0:7][23:0] i_channels,
  input  logic [3:0]       i_user,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_adat,
  output logic             o_frame_start,
  output logic             o_underrun,
  output logic             o_overrun,
  output logic             o_active
);

  localparam logic [31:0] INC  = 32'(SAMPLE_RATE * 256);
  localparam logic [31:0] FREQ = 32'(CLK_FREQ);

  typedef enum logic [1:0] {IDLE, SYNC, USER, DATA} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_acc;
  logic             r_tick;
  logic [31:0]      w_sum;
  logic [0:7][23:0] r_hold_ch;
  logic [3:0]       r_hold_user;
  logic             r_full;
  logic [0:255]     r_shift;
  logic [0:255]     w_fmt;
  logic [7:0]       r_bit_cnt;
  logic             r_adat;
  logic             w_advance;
  logic             w_load;

  // Fractional bit-rate generator; acc < CLK_FREQ < 2^31 so the sum cannot wrap.
  assign w_sum = r_acc + INC;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (w_sum >= FREQ) begin
      r_acc  <= w_sum - FREQ;
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_sum;
      r_tick <= 1'b0;
    end
  end

  // A tick emits a bit once transmission has started, or starts it from IDLE
  // when there is data waiting. Bit 0 of every frame is the load point.
  assign w_advance = r_tick && ((r_state != IDLE) || r_full);
  assign w_load    = w_advance && (r_bit_cnt == 8'd0);

  // Line image of the holding buffer; w_fmt[i] is frame bit i.
  assign w_fmt[0:9]   = '0;
  assign w_fmt[10]    = 1'b1;
  assign w_fmt[11:14] = r_hold_user;
  assign w_fmt[15]    = 1'b1;

  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    for (genvar gj = 0; gj < 6; gj++) begin : g_nib
      localparam int BASE = 16 + gi * 30 + gj * 5;
      assign w_fmt[BASE +: 4] = r_hold_ch[gi][23 - gj * 4 -: 4];
      assign w_fmt[BASE + 4]  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_ch   <= '0;
      r_hold_user <= '0;
      r_full      <= 1'b0;
    end else begin
      if (w_load) begin
        r_full <= 1'b0;
      end
      // A write in the load cycle lands after the transfer and keeps holding full.
      if (i_valid) begin
        r_hold_ch   <= i_channels;
        r_hold_user <= i_user;
        r_full      <= 1'b1;
      end
    end
  end

  // The shift buffer rotates rather than shifts, so after 256 ticks it holds the
  // same frame again with bit 0 at the head; an underrun therefore retransmits
  // for free. On load the new image goes in already rotated by one, because
  // bit 0 (always 0) is emitted in the load tick itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
    end else if (w_load && r_full) begin
      r_shift <= {w_fmt[1:255], w_fmt[0]};
    end else if (w_advance) begin
      r_shift <= {r_shift[1:255], r_shift[0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_adat    <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_advance) begin
      r_bit_cnt <= r_bit_cnt + 8'd1;
      if (r_shift[0]) begin
        r_adat <= ~r_adat;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_advance) begin
      case (r_state)
        IDLE:    w_state_next = SYNC;
        SYNC:    if (r_bit_cnt == 8'd10)  w_state_next = USER;
        USER:    if (r_bit_cnt == 8'd15)  w_state_next = DATA;
        DATA:    if (r_bit_cnt == 8'd255) w_state_next = SYNC;
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign o_ready       = ~r_full;
  assign o_adat        = r_adat;
  assign o_frame_start = w_load;
  assign o_underrun    = w_load && !r_full;
  assign o_overrun     = i_valid && r_full && !w_load;
  assign o_active      = (r_state != IDLE);

endmodule
